// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the restoring divider:
//   - DEF_WIDTH : default operand/result width. It matches the multiplier
//                 datapath that sits beside the divider.
//   - DEF_CNT_W : iteration counter width for DEF_WIDTH.
//   - div_state_e : controller states.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational step of restoring division. The incoming quotient msb is
// shifted into the partial remainder. The divisor is then subtracted at
// WIDTH+1 bits, and the difference is kept only if it did not go negative.
//
// Ports:
//   r_i      partial remainder before this step (always < divisor)
//   q_msb_i  msb of the quotient/shift register, shifted into the remainder
//   d_i      divisor
//   r_o      partial remainder after this step
//   q_bit_o  quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] diff;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        r_shift = {r_i, q_msb_i};
        // Two's-complement subtract: R + ~D + 1. A set msb means R < D.
        diff    = r_shift + ~{1'b0, d_i} + {{WIDTH{1'b0}}, 1'b1};
        r_o     = r_shift[WIDTH-1:0];
        q_bit_o = 1'b0;
        if (!diff[WIDTH]) begin
            r_o     = diff[WIDTH-1:0];
            q_bit_o = 1'b1;
        end
    end

endmodule : div_step

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Sequential unsigned divider that produces one quotient bit per clock.
// A start is accepted in IDLE or FIN. A non-zero divide spends WIDTH cycles in
// RUN and then one cycle in FIN, so the result appears WIDTH+1 cycles after
// acceptance. A zero divisor goes straight to FIN and finishes in one cycle.
// Results stay on the outputs until the next result replaces them.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        division request, honoured only when not in RUN
//   dividend     unsigned dividend, sampled on an accepted start
//   divisor      unsigned divisor, sampled on an accepted start
//   busy         high in RUN and FIN
//   done         one-cycle pulse, result outputs just updated
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (the dividend on divide by zero)
//   div_by_zero  set with done when the divisor was zero
// -----------------------------------------------------------------------------
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    // The restored remainder is always below the divisor, so its top bit is
    // always zero. Only the shifted value inside div_step needs WIDTH+1 bits.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             dbz_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic             q_bit;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[WIDTH-1]),
        .d_i     (d_q),
        .r_o     (r_d),
        .q_bit_o (q_bit)
    );

    assign q_d    = {q_q[WIDTH-2:0], q_bit};
    // FIN accepts a start as IDLE does, which allows back-to-back operation.
    assign accept = start && (state_q != RUN);

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            r_q           <= '0;
            q_q           <= '0;
            d_q           <= '0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            unique case (state_q)
                IDLE: ;
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q        <= 1'b1;
                    quotient_q    <= q_q;
                    remainder_q   <= r_q;
                    div_by_zero_q <= dbz_q;
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            // This block comes after the case, so it overrides FIN's return to
            // IDLE when a new operation is accepted in the same cycle.
            if (accept) begin
                busy_q <= 1'b1;
                if (divisor == '0) begin
                    q_q     <= '1;
                    r_q     <= dividend;
                    dbz_q   <= 1'b1;
                    state_q <= FIN;
                end else begin
                    q_q     <= dividend;
                    d_q     <= divisor;
                    r_q     <= '0;
                    cnt_q   <= '0;
                    dbz_q   <= 1'b0;
                    state_q <= RUN;
                    // In FIN the flag is presented together with the finishing
                    // result, so it is cleared early only from IDLE.
                    if (state_q == IDLE) begin
                        div_by_zero_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider
// Scoreboard bench. Each issued division pushes its expected result and its
// expected done cycle. A monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_restoring_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_quotient"}, 32'(quotient), 32'(e.q));
                check({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
                check({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    // Called just after a posedge. The start is accepted at the next edge k.
    // On return the time is just after edge k.
    task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        exp_t e;
        int k;
        k          = cyc + 1;
        e.q        = eq;
        e.r        = er;
        e.dbz      = edbz;
        e.done_cyc = (b == '0) ? k + 1 : k + W + 1;
        e.name     = name;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic model_issue(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) issue($sformatf("rnd%0d", idx), a, b, '1, a, 1'b1);
        else         issue($sformatf("rnd%0d", idx), a, b, a / b, a % b, 1'b0);
    endtask

    initial begin
        int k;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        // 100/7: busy must stay high from acceptance until the done edge.
        issue("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            check($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
            check($sformatf("nodone_run%0d", i), 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
        wait_idle();

        issue("dffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        wait_idle();
        issue("dffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        wait_idle();
        issue("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        wait_idle();
        issue("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        wait_idle();

        // A start during RUN must be ignored.
        issue("d1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset taken on the 8th iteration edge discards the operation.
        issue("d40000_123_aborted", 16'd40000, 16'd123, 16'd325, 16'd25, 1'b0);
        k = cyc;
        while (cyc < k + 7) @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        repeat (W + 4) @(posedge clk);
        #1;
        issue("d40000_123", 16'd40000, 16'd123, 16'd325, 16'd25, 1'b0);
        wait_idle();

        // Back-to-back: the second start is held during FIN of the first.
        issue("d17_5", 16'd17, 16'd5, 16'd3, 16'd2, 1'b0);
        repeat (W) @(posedge clk);
        #1;
        issue("d9_4_b2b", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0);
        wait_idle();

        // Random pairs checked against a / b and a % b, with occasional zeros.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom_range(0, 65535));
            if (i % 50 == 7)     b = '0;
            else if (i % 3 == 0) b = W'($urandom_range(1, 255));
            else                 b = W'($urandom_range(1, 65535));
            model_issue(i, a, b);
            wait_idle();
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_restoring_divider
